// File: rtl/seq_ram_writer.sv
// seq_ram_writer: sequencer recording front end for a single-port RAM.
// Accepts a stream of step words and writes them to consecutive RAM
// addresses from 0. Can also zero-fill the whole RAM.
//
// Parameters:
//   ADDR_W : RAM address width (DEPTH = 2**ADDR_W)
//   DATA_W : RAM word width
// Ports:
//   CLK_50     : clock, rising edge
//   reset      : asynchronous active-high reset
//   clear      : pulse, zero-fill the RAM (sweep of DEPTH writes)
//   rec_start  : pulse, start recording at address 0
//   rec_stop   : pulse, stop recording
//   step_valid : step_data valid this cycle
//   step_data  : word to record
//   step_ready : word accepted this cycle (RECORD state only)
//   wraddress  : registered RAM write address
//   data       : registered RAM write data
//   wren       : registered RAM write enable
//   count      : words recorded since the last rec_start or clear
//   busy       : clearing or recording
//   full       : DEPTH words recorded, further words refused
//   checksum   : XOR of all recorded words (only with SEQ_WR_CHECKSUM_EN)
// Optional feature macro: SEQ_WR_CHECKSUM_EN
module seq_ram_writer #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK_50,
  input  logic              reset,
  input  logic              clear,
  input  logic              rec_start,
  input  logic              rec_stop,
  input  logic              step_valid,
  input  logic [DATA_W-1:0] step_data,
  output logic              step_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic [ADDR_W:0]   count,
`ifdef SEQ_WR_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              busy,
  output logic              full
);

  // Count value just before the last free slot is taken.
  localparam logic [ADDR_W:0] CountLast = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {StIdle, StClear, StRecord, StFull} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   wraddress_q, wraddress_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wren_q, wren_d;
  logic                go_clear, go_rec, rec_write;
`ifdef SEQ_WR_CHECKSUM_EN
  logic [DATA_W-1:0]   checksum_q, checksum_d;
`endif

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wraddress_q <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
`ifdef SEQ_WR_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wraddress_q <= wraddress_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
`ifdef SEQ_WR_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    wraddress_d = wraddress_q;
    data_d      = data_q;
    wren_d      = 1'b0;
    go_clear    = 1'b0;
    go_rec      = 1'b0;
    rec_write   = 1'b0;
`ifdef SEQ_WR_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif

    unique case (state_q)
      StIdle: begin
        go_clear = clear;
        go_rec   = !clear && rec_start;
      end
      StClear: begin
        // wraddress_q holds the sweep index; all control inputs are ignored.
        if (&wraddress_q) begin
          state_d = StIdle;
        end else begin
          wren_d      = 1'b1;
          wraddress_d = wraddress_q + ADDR_W'(1);
          data_d      = '0;
        end
      end
      StRecord: begin
        go_clear = clear;
        go_rec   = !clear && rec_start;
        if (!clear && !rec_start) begin
          rec_write = step_valid;
          if (step_valid && (count_q == CountLast)) begin
            state_d = StFull;
          end else if (rec_stop) begin
            state_d = StIdle;
          end
        end
      end
      StFull: begin
        go_clear = clear;
        go_rec   = !clear && rec_start;
        if (!clear && !rec_start && rec_stop) begin
          state_d = StIdle;
        end
      end
    endcase

    if (rec_write) begin
      wren_d      = 1'b1;
      wraddress_d = wr_ptr_q;
      data_d      = step_data;
      // Wraps to 0 on the last slot; FULL never writes through it.
      wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
      count_d     = count_q + (ADDR_W+1)'(1);
`ifdef SEQ_WR_CHECKSUM_EN
      checksum_d  = checksum_q ^ step_data;
`endif
    end

    if (go_clear) begin
      // First sweep write goes out on the entry edge.
      state_d     = StClear;
      count_d     = '0;
      wren_d      = 1'b1;
      wraddress_d = '0;
      data_d      = '0;
`ifdef SEQ_WR_CHECKSUM_EN
      checksum_d  = '0;
`endif
    end

    if (go_rec) begin
      state_d    = StRecord;
      wr_ptr_d   = '0;
      count_d    = '0;
`ifdef SEQ_WR_CHECKSUM_EN
      checksum_d = '0;
`endif
    end
  end

  assign step_ready = (state_q == StRecord);
  assign busy       = (state_q == StClear) || (state_q == StRecord);
  assign full       = (state_q == StFull);
  assign wraddress  = wraddress_q;
  assign data       = data_q;
  assign wren       = wren_q;
  assign count      = count_q;
`ifdef SEQ_WR_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_seq_ram_writer.sv
// Self-checking bench for seq_ram_writer: constant vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_seq_ram_writer;

  localparam int DEPTH = 128;
  localparam int M_IDLE = 0, M_CLR = 1, M_REC = 2, M_FULL = 3;

  logic        CLK_50 = 1'b0;
  logic        reset, clear, rec_start, rec_stop, step_valid;
  logic [31:0] step_data;
  logic        step_ready, wren, busy, full;
  logic [6:0]  wraddress;
  logic [31:0] data;
  logic [7:0]  count;
`ifdef SEQ_WR_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  seq_ram_writer dut (
    .CLK_50     (CLK_50),
    .reset      (reset),
    .clear      (clear),
    .rec_start  (rec_start),
    .rec_stop   (rec_stop),
    .step_valid (step_valid),
    .step_data  (step_data),
    .step_ready (step_ready),
    .wraddress  (wraddress),
    .data       (data),
    .wren       (wren),
    .count      (count),
`ifdef SEQ_WR_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .busy       (busy),
    .full       (full)
  );

  always #5 CLK_50 = ~CLK_50;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: address of a recorded word is simply its ordinal.
  int          m_mode, m_cnt, m_clr_pos;
  bit          m_wr;
  int          m_addr;
  logic [31:0] m_data, m_cks;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_clr_pos = -1;
    m_wr = 0; m_addr = 0; m_data = 0; m_cks = 0;
  endtask

  task automatic put_write(input int a, input logic [31:0] d);
    m_wr = 1; m_addr = a; m_data = d;
  endtask

  task automatic start_clear();
    m_mode = M_CLR; m_cnt = 0; m_cks = 0; m_clr_pos = 0;
    put_write(0, 32'h0);
  endtask

  task automatic start_rec();
    m_mode = M_REC; m_cnt = 0; m_cks = 0;
  endtask

  task automatic model_step(input bit c, rs, rp, v, input logic [31:0] d);
    m_wr = 0;
    case (m_mode)
      M_IDLE: if (c) start_clear(); else if (rs) start_rec();
      M_CLR: begin
        if (m_clr_pos == DEPTH - 1) begin
          m_mode = M_IDLE; m_clr_pos = -1;
        end else begin
          m_clr_pos++;
          put_write(m_clr_pos, 32'h0);
        end
      end
      M_REC: begin
        if (c) start_clear();
        else if (rs) start_rec();
        else begin
          if (v) begin
            put_write(m_cnt % DEPTH, d);
            m_cks ^= d;
            m_cnt++;
          end
          if (m_cnt == DEPTH) m_mode = M_FULL;
          else if (rp) m_mode = M_IDLE;
        end
      end
      default: if (c) start_clear(); else if (rs) start_rec(); else if (rp) m_mode = M_IDLE;
    endcase
  endtask

  task automatic model_check();
    chk("wren", wren, m_wr);
    chk("wraddress", wraddress, m_addr);
    chk("data", data, m_data);
    chk("count", count, m_cnt);
    chk("busy", busy, (m_mode == M_CLR) || (m_mode == M_REC));
    chk("full", full, m_mode == M_FULL);
    chk("step_ready", step_ready, m_mode == M_REC);
`ifdef SEQ_WR_CHECKSUM_EN
    chk("checksum", checksum, m_cks);
`endif
  endtask

  // Apply inputs for one cycle, advance model, sample 1 ns after the edge.
  task automatic tick(input bit c, rs, rp, v, input logic [31:0] d);
    clear = c; rec_start = rs; rec_stop = rp; step_valid = v; step_data = d;
    model_step(c, rs, rp, v, d);
    @(posedge CLK_50);
    #1;
    model_check();
  endtask

  task automatic idle_tick();
    tick(0, 0, 0, 0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear = 0; rec_start = 0; rec_stop = 0; step_valid = 0; step_data = 0;
    model_reset();
    @(posedge CLK_50);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit c, rs, rp, v;
    logic [31:0] d;
    bit e_wren;
    int e_addr;
    logic [31:0] e_data;
    int e_cnt;
    bit e_busy;
    bit e_full;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int wr_seen;
    bit sweep_ok;

    tbl[0] = '{0, 1, 0, 0, 32'h0,  0, 0, 32'h0,  0, 1, 0};  // rec_start
    tbl[1] = '{0, 0, 0, 1, 32'hA,  1, 0, 32'hA,  1, 1, 0};
    tbl[2] = '{0, 0, 0, 1, 32'hB,  1, 1, 32'hB,  2, 1, 0};
    tbl[3] = '{0, 0, 0, 1, 32'hC,  1, 2, 32'hC,  3, 1, 0};
    tbl[4] = '{0, 0, 0, 0, 32'h0,  0, 2, 32'hC,  3, 1, 0};  // outputs hold
    tbl[5] = '{0, 0, 1, 1, 32'h55, 1, 3, 32'h55, 4, 0, 0};  // stop + word
    tbl[6] = '{0, 0, 0, 0, 32'h0,  0, 3, 32'h55, 4, 0, 0};
    tbl[7] = '{1, 1, 0, 0, 32'h0,  1, 0, 32'h0,  0, 1, 0};  // clear wins

    // Reset state, checked while reset is held.
    reset = 1'b1;
    clear = 0; rec_start = 0; rec_stop = 0; step_valid = 0; step_data = 0;
    model_reset();
    #2;
    chk("rst_wren", wren, 0);
    chk("rst_addr", wraddress, 0);
    chk("rst_data", data, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_ready", step_ready, 0);
    @(posedge CLK_50);
    #1;
    reset = 1'b0;

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].c, tbl[i].rs, tbl[i].rp, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_wren", i), wren, tbl[i].e_wren);
      chk($sformatf("tbl%0d_addr", i), wraddress, tbl[i].e_addr);
      chk($sformatf("tbl%0d_data", i), data, tbl[i].e_data);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
    end
    // Finish the sweep begun by the last row; controls must be ignored.
    for (int i = 1; i < DEPTH; i++) tick(1, 1, 1, 1, 32'hDEAD);
    idle_tick();

    // Full clear sweep from reset.
    do_reset();
    tick(1, 0, 0, 0, 32'h0);
    sweep_ok = (wren === 1'b1) && (wraddress === 7'd0) && (data === 32'h0);
    for (int i = 1; i < DEPTH; i++) begin
      idle_tick();
      if (!((wren === 1'b1) && (wraddress == 7'(i)) && (data === 32'h0))) sweep_ok = 0;
    end
    chk("sweep_128_writes", sweep_ok, 1);
    idle_tick();
    chk("sweep_end_busy", busy, 0);
    chk("sweep_end_wren", wren, 0);
    chk("sweep_end_count", count, 0);

    // Stream DEPTH words to FULL, then a refused word.
    tick(0, 1, 0, 0, 32'h0);
    for (int i = 0; i < DEPTH; i++) tick(0, 0, 0, 1, 32'h1000 + i);
    chk("full_flag", full, 1);
    chk("full_ready", step_ready, 0);
    chk("full_count", count, DEPTH);
    chk("full_last_addr", wraddress, DEPTH - 1);
    tick(0, 0, 0, 1, 32'hBAD);
    chk("full_no_write", wren, 0);
    tick(0, 0, 1, 0, 32'h0);  // rec_stop in FULL holds count
    chk("full_stop_count", count, DEPTH);
    chk("full_stop_full", full, 0);

    // rec_stop with a word at count=5.
    tick(0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 32'h20 + i);
    tick(0, 0, 1, 1, 32'h55);
    chk("stop_addr", wraddress, 5);
    chk("stop_data", data, 32'h55);
    chk("stop_count", count, 6);
    chk("stop_busy", busy, 0);

    // rec_start while recording restarts at 0; clear discards the word.
    tick(0, 1, 0, 0, 32'h0);
    tick(0, 0, 0, 1, 32'h77);
    tick(0, 0, 0, 1, 32'h78);
    tick(0, 1, 0, 0, 32'h0);
    tick(0, 0, 0, 1, 32'h79);
    chk("restart_addr", wraddress, 0);
    chk("restart_count", count, 1);
    tick(1, 0, 0, 1, 32'h99);
    chk("abort_data", data, 0);
    chk("abort_addr", wraddress, 0);

    // Reset at sweep index 40.
    for (int i = 1; i <= 40; i++) idle_tick();
    chk("mid_sweep_addr", wraddress, 40);
    #2;
    reset = 1'b1;
    #1;
    chk("async_wren", wren, 0);
    chk("async_addr", wraddress, 0);
    chk("async_count", count, 0);
    chk("async_busy", busy, 0);
    model_reset();
    @(posedge CLK_50);
    #1;
    reset = 1'b0;
    wr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      idle_tick();
      if (wren === 1'b1) wr_seen++;
    end
    chk("post_reset_writes", wr_seen, 0);

`ifdef SEQ_WR_CHECKSUM_EN
    tick(0, 1, 0, 0, 32'h0);
    tick(0, 0, 0, 1, 32'h0F);
    tick(0, 0, 0, 1, 32'hF0);
    chk("cks_ff", checksum, 32'hFF);
    tick(0, 1, 0, 0, 32'h0);
    chk("cks_restart", checksum, 0);
`endif

    // Randomized traffic; phases with rare controls let FULL be reached.
    for (int ph = 0; ph < 4; ph++) begin
      int unsigned div;
      div = (ph == 0) ? 8 : (ph == 1) ? 40 : 400;
      for (int i = 0; i < 600; i++) begin
        bit c, rs, rp, v;
        c  = ($urandom_range(div * 4 - 1) == 0);
        rs = ($urandom_range(div - 1) == 0);
        rp = ($urandom_range(div - 1) == 0);
        v  = ($urandom_range(3) != 0);
        tick(c, rs, rp, v, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_ram_writer.md
SEQ_RAM_WRITER -- requirements
Module: seq_ram_writer

Interface
REQ-001 The parameter ADDR_W SHALL default to 7 and set the RAM write-address width (DEPTH = 2**ADDR_W = 128).
REQ-002 The parameter DATA_W SHALL default to 32 and set the RAM word width.
REQ-003 CLK_50  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  one-cycle pulse: zero-fill the whole RAM.
REQ-006 rec_start  input  1  one-cycle pulse: begin recording at address 0.
REQ-007 rec_stop  input  1  one-cycle pulse: end recording.
REQ-008 step_valid  input  1  step_data is valid this cycle.
REQ-009 step_data  input  DATA_W  sequence word to store.
REQ-010 step_ready  output  1  block accepts a word this cycle.
REQ-011 wraddress  output  ADDR_W  RAM write address, registered.
REQ-012 data  output  DATA_W  RAM write data, registered.
REQ-013 wren  output  1  RAM write enable, registered, one cycle per write.
REQ-014 count  output  ADDR_W+1  number of words recorded since the last rec_start or clear (0..DEPTH).
REQ-015 busy  output  1  high in CLEAR or RECORD.
REQ-016 full  output  1  high in FULL.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, CLEAR, RECORD and FULL.
REQ-018 IDLE: clear -> CLEAR; rec_start -> RECORD with wr_ptr=0 and count=0; if both are asserted in the same cycle, clear SHALL win.
REQ-019 CLEAR: the block SHALL drive wren=1, data=0 and wraddress=0,1,..,DEPTH-1 on DEPTH consecutive cycles, then return to IDLE with count=0.
REQ-020 In CLEAR, rec_start, rec_stop, clear and step_valid SHALL be ignored; step_ready=0.
REQ-021 step_ready SHALL equal 1 only in RECORD, decoded combinationally from the state.
REQ-022 An accept (step_valid&&step_ready) in cycle N SHALL produce wren=1, wraddress=wr_ptr and data=step_data in cycle N+1; wr_ptr and count SHALL increment by 1.
REQ-023 Back-to-back accepts SHALL sustain one write per cycle with no bubble.
REQ-024 When the accept that brings count to DEPTH occurs, the FSM SHALL enter FULL on the next edge; wr_ptr SHALL wrap to 0 and not be used for writing.
REQ-025 rec_stop in RECORD -> IDLE; an accept in the same cycle as rec_stop SHALL still be written.
REQ-026 clear in RECORD SHALL abort the recording and enter CLEAR; an accept in that same cycle SHALL be discarded.
REQ-027 FULL: step_ready=0 and full=1; rec_start -> RECORD (count=0), clear -> CLEAR, rec_stop -> IDLE (count is held).
REQ-028 rec_start while already in RECORD SHALL restart at address 0 with count=0.
REQ-029 wren SHALL be 0 in every cycle not stated above; data and wraddress SHALL hold their last value when wren=0.

Reset
REQ-030 reset SHALL immediately force IDLE and set wraddress=0, data=0, wren=0, count=0, busy=0, full=0 and wr_ptr=0.
REQ-031 Reset asserted mid-CLEAR or mid-RECORD SHALL abort the operation with no further wren pulse after reset deasserts.

Configuration
REQ-032 With SEQ_WR_CHECKSUM_EN defined, the block SHALL add the output checksum[DATA_W-1:0], equal to the XOR of every word written in RECORD, cleared by reset, rec_start and clear, and updated in the same cycle as wren.
REQ-033 Without SEQ_WR_CHECKSUM_EN, the checksum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Apply reset, then pulse clear -> 128 consecutive wren cycles with wraddress 0..127 and data=0; busy drops the next cycle; count=0.
REQ-035 Pulse rec_start, then send 3 words (0xA, 0xB, 0xC) back-to-back -> wren on 3 consecutive cycles, one cycle after each accept, at addresses 0,1,2; count=3.
REQ-036 Stream 128 words -> full=1 after the 128th accept, step_ready=0, and a 129th step_valid produces no write.
REQ-037 Pulse rec_stop together with a valid word 0x55 at count=5 -> 0x55 is written at address 5, the FSM goes to IDLE and count=6.
REQ-038 Assert reset at the CLEAR sweep index 40 -> wren=0 immediately, all outputs reset, and no writes occur afterwards.
REQ-039 With SEQ_WR_CHECKSUM_EN defined, write 0x0F then 0xF0 -> checksum=0xFF; after rec_start, checksum=0.
